// File: rtl/motion_update_broadcaster.sv
// Motion-update broadcast transmitter: buffers particle records, frames each run with
// motion_update_enable and pulses done once the caches have settled. Optional macro: MU_BCAST_DST_CHECK_EN.
module motion_update_broadcaster #(
  parameter int DATA_WIDTH      = 32,
  parameter int CELL_ID_WIDTH   = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter int FIFO_ADDR_WIDTH = 3,
  parameter int CNT_WIDTH       = 16,
  parameter int SETTLE_CYCLES   = 3
`ifdef MU_BCAST_DST_CHECK_EN
  ,
  parameter int X_MAX           = 3,
  parameter int Y_MAX           = 3,
  parameter int Z_MAX           = 3
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       upd_valid,
  output logic                       upd_ready,
  input  logic [3*DATA_WIDTH-1:0]    upd_data,
  input  logic [3*CELL_ID_WIDTH-1:0] upd_dst_cell,
  input  logic                       upd_done,
  output logic                       motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]    out_data,
  output logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell,
  output logic                       out_data_valid,
  output logic [CNT_WIDTH-1:0]       bcast_count,
  output logic                       done,
  output logic                       dst_err
);
  localparam int REC_W    = 3 * DATA_WIDTH;
  localparam int DST_W    = 3 * CELL_ID_WIDTH;
  localparam int ENT_W    = REC_W + DST_W;
  localparam int SETTLE_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [FIFO_ADDR_WIDTH:0] PTR_ONE    = {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]     CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SETTLE_W-1:0]      SETTLE_ONE = {{(SETTLE_W-1){1'b0}}, 1'b1};
  localparam logic [SETTLE_W-1:0]      SETTLE_INI = SETTLE_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BCAST  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [FIFO_ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0]         mem_q [FIFO_DEPTH];
  logic                     enable_q, enable_d;
  logic                     valid_q, valid_d;
  logic                     done_q, done_d;
  logic                     done_seen_q, done_seen_d;
  logic                     dst_err_q, dst_err_d;
  logic [REC_W-1:0]         data_q, data_d;
  logic [DST_W-1:0]         dst_q, dst_d;
  logic [CNT_WIDTH-1:0]     count_q, count_d;
  logic [SETTLE_W-1:0]      settle_q, settle_d;
  logic                     fifo_empty_s, fifo_full_s, ready_s, accept_s, push_s, dst_ok_s;
  logic [ENT_W-1:0]         head_s;

`ifdef MU_BCAST_DST_CHECK_EN
  function automatic logic dst_legal(input logic [DST_W-1:0] dst);
    logic [CELL_ID_WIDTH-1:0] cx, cy, cz;
    {cx, cy, cz} = dst;
    return (int'(cx) <= X_MAX) && (int'(cy) <= Y_MAX) && (int'(cz) <= Z_MAX);
  endfunction

  assign dst_ok_s = dst_legal(upd_dst_cell);
`else
  assign dst_ok_s = 1'b1;
`endif

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[FIFO_ADDR_WIDTH] != rd_ptr_q[FIFO_ADDR_WIDTH]) &&
                        (wr_ptr_q[FIFO_ADDR_WIDTH-1:0] == rd_ptr_q[FIFO_ADDR_WIDTH-1:0]);
  assign ready_s      = (state_q == ST_BCAST) && !fifo_full_s;
  assign accept_s     = upd_valid && ready_s;
  assign push_s       = accept_s && dst_ok_s;
  assign head_s       = mem_q[rd_ptr_q[FIFO_ADDR_WIDTH-1:0]];

  // Next-state and next-output computation for the broadcast sequencer.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    enable_d    = enable_q;
    done_seen_d = done_seen_q;
    dst_err_d   = dst_err_q;
    count_d     = count_q;
    settle_d    = settle_q;
    valid_d     = 1'b0;
    data_d      = '0;
    dst_d       = '0;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_BCAST;
          enable_d    = 1'b1;
          count_d     = '0;
          dst_err_d   = 1'b0;
          done_seen_d = 1'b0;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BCAST: begin
        if (push_s) begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
        if (accept_s && !dst_ok_s) begin
          dst_err_d = 1'b1;
        end else begin
          dst_err_d = dst_err_q;
        end
        if (upd_done) begin
          done_seen_d = 1'b1;
        end else begin
          done_seen_d = done_seen_q;
        end
        // Drain takes priority; the run only closes once the buffer is empty.
        if (!fifo_empty_s) begin
          rd_ptr_d        = rd_ptr_q + PTR_ONE;
          valid_d         = 1'b1;
          {dst_d, data_d} = head_s;
          if (count_q != {CNT_WIDTH{1'b1}}) begin
            count_d = count_q + CNT_ONE;
          end else begin
            count_d = count_q;
          end
        end else if (done_seen_q) begin
          enable_d = 1'b0;
          state_d  = ST_SETTLE;
          settle_d = SETTLE_INI;
        end else begin
          state_d = ST_BCAST;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_DONE;
        end else begin
          settle_d = settle_q - SETTLE_ONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        enable_d = 1'b0;
      end
    endcase
  end

  // Sequencer, pointer and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      enable_q    <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      done_seen_q <= 1'b0;
      dst_err_q   <= 1'b0;
      data_q      <= '0;
      dst_q       <= '0;
      count_q     <= '0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      enable_q    <= enable_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      done_seen_q <= done_seen_d;
      dst_err_q   <= dst_err_d;
      data_q      <= data_d;
      dst_q       <= dst_d;
      count_q     <= count_d;
      settle_q    <= settle_d;
    end
  end

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[FIFO_ADDR_WIDTH-1:0]] <= {upd_dst_cell, upd_data};
    end
  end

  assign upd_ready            = ready_s;
  assign motion_update_enable = enable_q;
  assign out_data             = data_q;
  assign out_data_dst_cell    = dst_q;
  assign out_data_valid       = valid_q;
  assign bcast_count          = count_q;
  assign done                 = done_q;
  assign dst_err              = dst_err_q;
endmodule

// File: tb/tb_motion_update_broadcaster.sv
// Bench for motion_update_broadcaster: plans each run as a list of push edges and derives
// beat, enable, ready, count and done timing from that plan alone.
module tb_motion_update_broadcaster;
  localparam int DW     = 32;
  localparam int CW     = 4;
  localparam int SETTLE = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              upd_valid = 1'b0;
  logic              upd_done = 1'b0;
  logic [3*DW-1:0]   upd_data = '0;
  logic [3*CW-1:0]   upd_dst_cell = '0;
  logic              upd_ready, motion_update_enable, out_data_valid, done, dst_err;
  logic [3*DW-1:0]   out_data;
  logic [3*CW-1:0]   out_data_dst_cell;
  logic [15:0]       bcast_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [3*DW-1:0] rec_data[$];
  logic [3*CW-1:0] rec_dst[$];

  motion_update_broadcaster dut (
    .clk(clk), .rst(rst), .start(start), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_data(upd_data), .upd_dst_cell(upd_dst_cell), .upd_done(upd_done),
    .motion_update_enable(motion_update_enable), .out_data(out_data),
    .out_data_dst_cell(out_data_dst_cell), .out_data_valid(out_data_valid),
    .bcast_count(bcast_count), .done(done), .dst_err(dst_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal(input logic [3*CW-1:0] d);
`ifdef MU_BCAST_DST_CHECK_EN
    return (d[3*CW-1:2*CW] <= 4'd3) && (d[2*CW-1:CW] <= 4'd3) && (d[CW-1:0] <= 4'd3);
`else
    return (d == d);
`endif
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_ready"}, upd_ready, 1'b0);
    check_eq({tag, "_enable"}, motion_update_enable, 1'b0);
    check_eq({tag, "_valid"}, out_data_valid, 1'b0);
    check_eq({tag, "_data"}, out_data, '0);
    check_eq({tag, "_dst"}, out_data_dst_cell, '0);
    check_eq({tag, "_count"}, bcast_count, '0);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_dst_err"}, dst_err, 1'b0);
  endtask

  function automatic logic [3*DW-1:0] rnd_rec();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Cycle c means "just after edge c"; start is sampled at edge 1.
  task automatic run_plan(input int gap_max, input int done_lag, input bit poke);
    int n, nxt, d_edge, last, end_e, dn_e, k, err_at, c;
    int p[$];
    int beat_at[$];
    logic [3*DW-1:0] bd[$];
    logic [3*CW-1:0] bt[$];
    n = rec_data.size();
    nxt = 2;
    for (int i = 0; i < n; i++) begin
      nxt += (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      p.push_back(nxt);
      nxt += 1;
    end
    d_edge = ((n > 0) ? p[n-1] : 2) + done_lag;
    last = 0;
    err_at = -1;
    for (int i = 0; i < n; i++) begin
      if (legal(rec_dst[i])) begin
        beat_at.push_back(p[i] + 1);
        bd.push_back(rec_data[i]);
        bt.push_back(rec_dst[i]);
        last = p[i] + 1;
      end else if (err_at < 0) begin
        err_at = p[i];
      end
    end
    end_e = ((d_edge > last) ? d_edge : last) + 1;
    dn_e  = end_e + SETTLE + 1;
    k = 0;
    for (int rc = 0; rc <= dn_e; rc++) begin
      start        = (rc == 0) || (poke && (rc == 3 || rc == end_e + 1));
      upd_valid    = 1'b0;
      upd_done     = (rc + 1 == d_edge);
      upd_data     = rnd_rec();
      upd_dst_cell = 12'($urandom());
      for (int i = 0; i < n; i++) begin
        if (p[i] == rc + 1) begin
          upd_valid    = 1'b1;
          upd_data     = rec_data[i];
          upd_dst_cell = rec_dst[i];
        end
      end
      if (poke && rc >= end_e) begin
        upd_valid = 1'($urandom());
        upd_done  = 1'($urandom());
      end
      tick();
      c = rc + 1;
      check_eq("enable", motion_update_enable, (c < end_e));
      check_eq("upd_ready", upd_ready, (c < end_e));
      check_eq("done", done, (c == dn_e));
      if (k < beat_at.size() && beat_at[k] == c) begin
        check_eq("valid", out_data_valid, 1'b1);
        check_eq("data", out_data, bd[k]);
        check_eq("dst", out_data_dst_cell, bt[k]);
        k++;
      end else begin
        check_eq("valid", out_data_valid, 1'b0);
        check_eq("idle_data", out_data, '0);
        check_eq("idle_dst", out_data_dst_cell, '0);
      end
      check_eq("count", bcast_count, k);
      check_eq("dst_err", dst_err, (err_at >= 0 && c >= err_at));
    end
    start = 1'b0;
    upd_valid = 1'b0;
    upd_done = 1'b0;
    check_eq("all_beats", k, beat_at.size());
    rec_data.delete();
    rec_dst.delete();
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      rec_data.push_back(rnd_rec());
      rec_dst.push_back(12'($urandom()));
    end
  endtask

  initial begin
    repeat (2) tick();
    check_idle("reset");
    rst = 1'b1;
    tick();

    // Three back-to-back records, upd_done with the last.
    rec_data = '{rnd_rec(), rnd_rec(), rnd_rec()};
    rec_dst  = '{{4'd2, 4'd1, 4'd3}, {4'd0, 4'd0, 4'd0}, {4'd2, 4'd1, 4'd3}};
    run_plan(0, 0, 1'b0);

    // Continuous stream longer than the buffer.
    fill_random(12);
    run_plan(0, 0, 1'b0);

    // Zero-record run.
    run_plan(0, 0, 1'b0);

    // Start pulses during broadcast and settle are ignored.
    fill_random(5);
    run_plan(2, 1, 1'b1);

    // Reset with records in flight, then a clean run.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1'b1;
      upd_data = rnd_rec();
      upd_dst_cell = 12'($urandom());
      tick();
    end
    upd_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_idle("rst_async");
    tick();
    check_idle("rst_hold");
    rst = 1'b1;
    tick();
    fill_random(4);
    run_plan(1, 2, 1'b0);

    for (int r = 0; r < 6; r++) begin
      fill_random(int'($urandom_range(10, 0)));
      run_plan(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'($urandom()));
    end

`ifdef MU_BCAST_DST_CHECK_EN
    rec_data = '{rnd_rec(), rnd_rec(), rnd_rec(), rnd_rec()};
    rec_dst  = '{{4'd0, 4'd1, 4'd2}, {4'd5, 4'd0, 4'd0}, {4'd1, 4'd1, 4'd1}, {4'd3, 4'd3, 4'd3}};
    run_plan(0, 0, 1'b0);
    run_plan(0, 0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/motion_update_broadcaster.md
Name: motion_update_broadcaster

Overview:
- Transmit end of the motion-update broadcast bus consumed by every per-cell position/velocity double-buffered cache.
- Accepts updated particle records with their destination cell from the motion-update pipeline and buffers them in a small FIFO.
- Broadcasts one record per cycle on the shared bus, framing the run with motion_update_enable.
- Guarantees cache settle time after each run before signalling done.

Parameters:
DATA_WIDTH, 32, width of one vector component; record is {z, y, x}
CELL_ID_WIDTH, 4, width of one cell coordinate; dst = {cell_x, cell_y, cell_z}
FIFO_DEPTH, 8, record buffer entries (power of 2)
FIFO_ADDR_WIDTH, 3, log2(FIFO_DEPTH)
CNT_WIDTH, 16, width of broadcast counter
SETTLE_CYCLES, 3, idle cycles after enable falls before done (cache count write + buffer flip)
X_MAX, 3, largest legal cell_x (optional feature only)
Y_MAX, 3, largest legal cell_y (optional feature only)
Z_MAX, 3, largest legal cell_z (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run (honoured only in IDLE)
upd_valid  in  1  upstream record valid
upd_ready  out  1  FIFO can accept
upd_data  in  3*DATA_WIDTH  updated record
upd_dst_cell  in  3*CELL_ID_WIDTH  destination cell of record
upd_done  in  1  end-of-stream pulse; may coincide with last upd_valid
motion_update_enable  out  1  high for whole broadcast run
out_data  out  3*DATA_WIDTH  broadcast record (zero when not valid)
out_data_dst_cell  out  3*CELL_ID_WIDTH  broadcast destination (zero when not valid)
out_data_valid  out  1  broadcast beat valid
bcast_count  out  CNT_WIDTH  records broadcast in current/last run
done  out  1  one-cycle pulse: run complete, caches settled
dst_err  out  1  sticky illegal-destination flag (optional feature)

Behaviour:
- Reset (rst low, async): state IDLE, FIFO empty, done_seen 0. All outputs 0, including upd_ready, enable, valid, data, dst, count, done and dst_err.
- FSM states: IDLE, BROADCAST, SETTLE, DONE.
- IDLE: start -> BROADCAST; at that edge enable<=1, bcast_count<=0, dst_err<=0, done_seen<=0. Start outside IDLE is ignored.
- BROADCAST:
  - upd_ready = FIFO not full.
  - Push when upd_valid && upd_ready. Pop when FIFO non-empty. Push and pop in the same cycle are both allowed; push on full is impossible because ready is low.
  - upd_done latches done_seen.
  - Accept-to-bus latency is 2 cycles: push at edge E, pop and output-register load at E+1, beat visible in cycle E+1..E+2.
  - Each beat increments bcast_count (saturating at all-ones).
  - Idle cycles drive valid=0, data=0, dst=0.
- End of run: in the first cycle with done_seen=1 and FIFO empty, the edge ending that cycle sets enable<=0, valid<=0 and state<=SETTLE with settle counter = SETTLE_CYCLES-1.
  - The final beat therefore always sees enable=1.
  - enable is never low while valid is high.
- SETTLE: upd_ready=0; counter decrements; at 0 -> DONE.
- DONE: done=1 for one cycle -> IDLE. bcast_count holds until the next start.
- Zero-record run: start then upd_done -> enable high ≥2 cycles with no beats, then settle, then done; count=0.
- upd_valid or upd_done in IDLE/SETTLE/DONE: ignored; upd_ready is 0 there.
- Reset mid-run: immediate return to reset state; buffered records are discarded.

Optional Feature:
- Macro MU_BCAST_DST_CHECK_EN.
- Defined:
  - At push, any coordinate > X_MAX/Y_MAX/Z_MAX drops the record: it is not written and not counted.
  - The handshake still completes (ready unaffected).
  - dst_err is set and stays set until the next start.
- Undefined: no check; every accepted record is broadcast; dst_err tied 0.

Test Plan:
- Reset with FIFO half full mid-run -> next cycle all outputs 0, state IDLE; new start runs normally with count from 0.
- Start, then 3 back-to-back records dst {2,1,3},{0,0,0},{2,1,3}, upd_done with the third:
  - 3 consecutive beats, first beat 2 cycles after first push.
  - enable falls the cycle after the third beat.
  - done exactly 1+SETTLE_CYCLES+1 cycles after that third beat cycle; bcast_count=3.
- Upstream pushes 12 records continuously, FIFO_DEPTH=8, with no downstream stall:
  - upd_ready never drops (one pop per cycle).
  - Records appear on the bus in push order; count=12.
- Start immediately followed by upd_done (no records):
  - enable high 2 cycles, no valid beats, done after settle, count=0.
- Start pulsed during BROADCAST and SETTLE -> ignored; count not cleared; exactly one done.
- MU_BCAST_DST_CHECK_EN with 4 records, second has cell_x=5 (X_MAX=3):
  - 3 beats, count=3, dst_err=1 through done; dst_err cleared on next start.
